systolic_feeder: RTL
====================

# systolic_feeder

Command-driven sequencer that drives the input side of `systolic_array`. It accepts one GEMM-tile command and reads ARRAY_SIZE weight columns from a local tile buffer, then loads them through the weight port. It then issues the start/clear pulse and streams M activation rows into the array with full valid/ready backpressure. It sits between the tile buffer SRAM and `systolic_array` and replaces the hand-sequenced stimulus used in the array's unit benches.

## Interface
- ARRAY_SIZE, 4, array dimension (columns loaded, lanes per row)
- DATA_WIDTH, 8, bits per element
- ADDR_WIDTH, 10, tile buffer word address width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_w_addr  in  ADDR_WIDTH  buffer address of weight column 0 (column c at cmd_w_addr+c)
- cmd_a_addr  in  ADDR_WIDTH  buffer address of activation row 0 (row r at cmd_a_addr+r)
- cmd_m_rows  in  16  number of activation rows to stream (0 legal)
- cmd_clear  in  1  value driven on clear_acc with start
- mem_rd_en  out  1  buffer read strobe
- mem_rd_addr  out  ADDR_WIDTH  buffer read address
- mem_rd_data  in  ARRAY_SIZE*DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- weight_load_en  out  1  weight column write
- weight_load_col  out  $clog2(ARRAY_SIZE)  column index
- weight_load_data  out  ARRAY_SIZE*DATA_WIDTH  column data, lane i = row i
- start  out  1  one-cycle start pulse to array
- clear_acc  out  1  one-cycle, coincident with start
- act_valid  out  1  activation row valid
- act_data  out  ARRAY_SIZE*DATA_WIDTH  activation row, lane i = A[r][i]
- act_ready  in  1  array accepts row
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE → W_LOAD → START → A_STREAM → DONE → IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields and go to W_LOAD.
- W_LOAD: issue ARRAY_SIZE reads on consecutive cycles, addresses cmd_w_addr+0..ARRAY_SIZE-1. Each returned word drives weight_load_en=1, weight_load_col=c, weight_load_data=mem_rd_data on the cycle after its read. After the last column write, go to START.
- START: start=1 and clear_acc=latched cmd_clear for exactly one cycle. If m_rows≠0, issue the read of row 0 in the same cycle. Go to A_STREAM, or to DONE if m_rows=0.
- A_STREAM: a 2-entry output buffer holds fetched rows. A read is issued only when outstanding reads plus occupied entries are fewer than 2 and rows remain unissued. act_valid = buffer non-empty. act_data = head entry. A beat transfers on act_valid&&act_ready. When m_rows beats have transferred, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Rows are delivered in address order, each exactly once, with no gaps and no duplicates under any act_ready pattern.
- While act_valid && !act_ready, act_data is held stable.
- Addresses wrap modulo 2^ADDR_WIDTH.
- A cmd_valid presented while busy is ignored (cmd_ready=0).
- Async reset at any point: state→IDLE, buffer emptied, counters cleared, outstanding read data discarded.

## Timing
- Reset values: cmd_ready=1; every other output is 0, including all data and address buses.
- Cycle 0: command accepted. Cycles 1..N (N=ARRAY_SIZE): weight reads. Cycles 2..N+1: weight_load_en.
- Cycle N+2: start/clear_acc pulse and read of row 0.
- Cycle N+3: act_valid first high.
- With act_ready held at 1, one row transfers per cycle. Row M-1 transfers at cycle N+2+M, and done pulses at N+3+M.
- m_rows=0: done pulses at cycle N+3.
- Next command is accepted no earlier than the cycle after done.

## Test plan
- 2x2 in 4x4 array: weights col0=[1,2,0,0], col1=[2,3,0,0], cols 2,3 zero; A rows [1,1,0,0],[2,2,0,0]; cmd_clear=1, act_ready=1 → weight writes at cycles 2–5 with matching data, start&clear_acc at cycle 6, act rows at cycles 7–8, done at cycle 9; the array produces C=[3,5;6,10].
- Identity weights with A rows 1..16 (row k = [4k+1..4k+4]) and M=4 → 4 act beats in order, the array outputs equal A, busy high from cycle 1 through cycle 11.
- Backpressure: act_ready toggles 1,0,0,1,0,1,… over M=8 rows → exactly 8 transfers in order, act_data is stable during stalls, and mem_rd_en never issues a read that would overflow the 2-entry buffer.
- m_rows=0, cmd_clear=0 → 4 weight writes, start=1 with clear_acc=0, no act_valid, done at cycle 7.
- Address wrap: cmd_a_addr=1022, M=4, ADDR_WIDTH=10 → mem_rd_addr sequence 1022,1023,0,1.
- Reset mid-stream: assert rst_n=0 after row 2 of 6 transfers → all outputs 0 and cmd_ready=1 immediately. After release, a new command with M=3 streams exactly 3 rows starting at its own cmd_a_addr.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Bus bundle between systolic_feeder and its environment: command channel,
// tile-buffer read port, weight load port, start/clear and activation stream.
interface systolic_feeder_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  // Command channel
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [ADDR_WIDTH-1:0]            cmd_w_addr;
  logic [ADDR_WIDTH-1:0]            cmd_a_addr;
  logic [15:0]                      cmd_m_rows;
  logic                             cmd_clear;
  // Tile buffer read port
  logic                             mem_rd_en;
  logic [ADDR_WIDTH-1:0]            mem_rd_addr;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_rd_data;
  // Weight load port
  logic                             weight_load_en;
  logic [$clog2(ARRAY_SIZE)-1:0]    weight_load_col;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_load_data;
  // Array control and activation stream
  logic                             start;
  logic                             clear_acc;
  logic                             act_valid;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_data;
  logic                             act_ready;
  // Status
  logic                             busy;
  logic                             done;

  // Feeder side
  modport master (
    input  cmd_valid, cmd_w_addr, cmd_a_addr, cmd_m_rows, cmd_clear,
    input  mem_rd_data, act_ready,
    output cmd_ready, mem_rd_en, mem_rd_addr,
    output weight_load_en, weight_load_col, weight_load_data,
    output start, clear_acc, act_valid, act_data, busy, done
  );

  // Environment side (command source, tile buffer, array)
  modport slave (
    output cmd_valid, cmd_w_addr, cmd_a_addr, cmd_m_rows, cmd_clear,
    output mem_rd_data, act_ready,
    input  cmd_ready, mem_rd_en, mem_rd_addr,
    input  weight_load_en, weight_load_col, weight_load_data,
    input  start, clear_acc, act_valid, act_data, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts one GEMM-tile command, loads ARRAY_SIZE weight
// columns from the tile buffer into the array, pulses start/clear_acc, then
// streams M activation rows through a 2-entry buffer with valid/ready.
module systolic_feeder #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input logic               clk,
  input logic               rst_n,
  systolic_feeder_if.master bus
);
  localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
  localparam int COL_W = $clog2(ARRAY_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_W_LOAD, S_START, S_A_STREAM, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [15:0]           m_rows_q, m_rows_d;
  logic                  clear_q, clear_d;
  logic [15:0]           issue_cnt_q, issue_cnt_d;  // reads issued in current phase
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;    // activation beats delivered
  logic [COL_W-1:0]      wr_col_q, wr_col_d;        // next weight column to write
  logic                  rd_pend_q, rd_pend_d;      // a read returns data this cycle
  logic [ROW_W-1:0]      row_buf_q [2];
  logic [ROW_W-1:0]      row_buf_d [2];
  logic                  head_q, head_d;
  logic [1:0]            cnt_q, cnt_d;              // occupied buffer entries
  logic                  push, pop;

  // Next-state, datapath updates and all outputs.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    w_addr_d    = w_addr_q;
    a_addr_d    = a_addr_q;
    m_rows_d    = m_rows_q;
    clear_d     = clear_q;
    issue_cnt_d = issue_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    wr_col_d    = wr_col_q;
    rd_pend_d   = 1'b0;
    row_buf_d   = row_buf_q;
    head_d      = head_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    pop         = 1'b0;

    bus.cmd_ready        = 1'b0;
    bus.mem_rd_en        = 1'b0;
    bus.mem_rd_addr      = '0;
    bus.weight_load_en   = 1'b0;
    bus.weight_load_col  = '0;
    bus.weight_load_data = '0;
    bus.start            = 1'b0;
    bus.clear_acc        = 1'b0;
    bus.act_valid        = 1'b0;
    bus.act_data         = '0;
    bus.busy             = (state_q != S_IDLE);
    bus.done             = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_addr_d    = bus.cmd_w_addr;
          a_addr_d    = bus.cmd_a_addr;
          m_rows_d    = bus.cmd_m_rows;
          clear_d     = bus.cmd_clear;
          issue_cnt_d = '0;
          xfer_cnt_d  = '0;
          wr_col_d    = '0;
          state_d     = S_W_LOAD;
        end
      end

      S_W_LOAD: begin
        if (issue_cnt_q < 16'(ARRAY_SIZE)) begin
          bus.mem_rd_en   = 1'b1;
          bus.mem_rd_addr = w_addr_q + ADDR_WIDTH'(issue_cnt_q);
          issue_cnt_d     = issue_cnt_q + 16'd1;
          rd_pend_d       = 1'b1;
        end
        // Returned column goes straight to the array on the cycle it arrives
        if (rd_pend_q) begin
          bus.weight_load_en   = 1'b1;
          bus.weight_load_col  = wr_col_q;
          bus.weight_load_data = bus.mem_rd_data;
          wr_col_d             = wr_col_q + 1'b1;
          if (wr_col_q == COL_W'(ARRAY_SIZE - 1)) begin
            issue_cnt_d = '0;
            state_d     = S_START;
          end
        end
      end

      S_START: begin
        bus.start     = 1'b1;
        bus.clear_acc = clear_q;
        head_d        = 1'b0;
        cnt_d         = '0;
        if (m_rows_q != 16'd0) begin
          bus.mem_rd_en   = 1'b1;
          bus.mem_rd_addr = a_addr_q;
          issue_cnt_d     = 16'd1;
          rd_pend_d       = 1'b1;
          state_d         = S_A_STREAM;
        end else begin
          state_d = S_DONE;
        end
      end

      S_A_STREAM: begin
        // A row arriving into an empty buffer is presented immediately; it
        // is stored only if the array does not take it this cycle.
        bus.act_valid = (cnt_q != 2'd0) || rd_pend_q;
        bus.act_data  = (cnt_q != 2'd0) ? row_buf_q[head_q] : bus.mem_rd_data;
        push = rd_pend_q && !((cnt_q == 2'd0) && bus.act_ready);
        pop  = (cnt_q != 2'd0) && bus.act_ready;
        if (push) row_buf_d[head_q ^ cnt_q[0]] = bus.mem_rd_data;
        if (pop)  head_d = ~head_q;
        cnt_d = cnt_q + 2'(push) - 2'(pop);

        // Never have more rows in flight or buffered than there are entries
        if (((2'(rd_pend_q) + cnt_q) < 2'd2) && (issue_cnt_q < m_rows_q)) begin
          bus.mem_rd_en   = 1'b1;
          bus.mem_rd_addr = a_addr_q + ADDR_WIDTH'(issue_cnt_q);
          issue_cnt_d     = issue_cnt_q + 16'd1;
          rd_pend_d       = 1'b1;
        end

        if (bus.act_valid && bus.act_ready) begin
          xfer_cnt_d = xfer_cnt_q + 16'd1;
          if (xfer_cnt_q + 16'd1 == m_rows_q) state_d = S_DONE;
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state register; reset discards any read in flight.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_addr_q    <= '0;
      a_addr_q    <= '0;
      m_rows_q    <= '0;
      clear_q     <= 1'b0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      wr_col_q    <= '0;
      rd_pend_q   <= 1'b0;
      head_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      w_addr_q    <= w_addr_d;
      a_addr_q    <= a_addr_d;
      m_rows_q    <= m_rows_d;
      clear_q     <= clear_d;
      issue_cnt_q <= issue_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      wr_col_q    <= wr_col_d;
      rd_pend_q   <= rd_pend_d;
      head_q      <= head_d;
      cnt_q       <= cnt_d;
    end
  end

  // Row buffer storage.
  // NOTE: data entries are not reset; cnt_q marks them empty and act_data is gated when invalid.
  always_ff @(posedge clk) begin
    row_buf_q <= row_buf_d;
  end
endmodule
